// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage that owns the PC, fetches over a ready handshake and applies decode redirects.
// Optional feature macro IF_ALIGN_CHECK_EN: a misaligned fetch address raises if_adel instead of issuing a request.
`default_nettype none

`ifndef COND_FLOW
`define COND_FLOW  2'b00
`endif
`ifndef COND_STALL
`define COND_STALL 2'b01
`endif
`ifndef COND_ZERO
`define COND_ZERO  2'b10
`endif
`ifndef IR_NON
`define IR_NON     32'h0000_0000
`endif

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cond,
  input  logic [2:0]  mux_pc_sel,
  input  logic [31:0] ext_out,
  input  logic [31:0] connect,
  input  logic [31:0] regfile_Rs,
  input  logic [31:0] cp0_EPC,
  input  logic [31:0] cp0_intr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_IR,
  output logic [31:0] if_NPC,
  output logic        fetch_busy,
  output logic        if_adel
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_FULL  = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, req_addr, req_addr_n, buf_ir, buf_ir_n, ir_n, npc_n;
  logic        buf_valid, buf_valid_n, adel, adel_n;
  logic [31:0] target, pc_inc, instr;
  logic        flow, sel_valid, redirect, avail, enter;

  assign pc_inc     = pc + 32'd4;
  assign flow       = (cond == `COND_FLOW);
  assign sel_valid  = (mux_pc_sel >= 3'd1) && (mux_pc_sel <= 3'd5);
  assign redirect   = flow && sel_valid;
  assign avail      = buf_valid || ((state == S_REQ) && imem_ready);
  assign instr      = buf_valid ? buf_ir : imem_rdata;
  assign fetch_busy = !avail && !sel_valid;
  assign imem_addr  = {req_addr[31:2], 2'b00};
  assign if_adel    = adel;

  always_comb begin
    case (mux_pc_sel)
      3'd1:    target = if_NPC + (ext_out << 2);
      3'd2:    target = connect;
      3'd3:    target = regfile_Rs;
      3'd4:    target = cp0_intr_addr;
      3'd5:    target = cp0_EPC;
      default: target = pc_inc;
    endcase
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_addr_n  = req_addr;
    buf_ir_n    = buf_ir;
    buf_valid_n = buf_valid;
    ir_n        = if_IR;
    npc_n       = if_NPC;
    adel_n      = adel;
    imem_req    = 1'b0;
    enter       = 1'b0;

    if (flow) begin
      if (redirect) begin
        ir_n   = `IR_NON;
        pc_n   = target;
        adel_n = 1'b0;
      end else if (avail) begin
        ir_n   = instr;
        npc_n  = pc_inc;
        pc_n   = pc_inc;
        adel_n = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      end else if (state == S_FAULT) begin
        ir_n   = `IR_NON;
        npc_n  = pc_inc;
        adel_n = 1'b1;
`endif
      end else begin
        ir_n   = `IR_NON;
        adel_n = 1'b0;
      end
    end else if (cond == `COND_ZERO) begin
      ir_n = `IR_NON;
    end

    // req_addr_n doubles as the address of the request about to be issued
    case (state)
      S_BOOT: begin
        enter      = 1'b1;
        req_addr_n = pc;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect && !imem_ready) begin
          state_n = S_DRAIN;
        end else if (redirect) begin
          enter      = 1'b1;
          req_addr_n = target;
        end else if (imem_ready && flow) begin
          enter      = 1'b1;
          req_addr_n = pc_inc;
        end else if (imem_ready) begin
          state_n     = S_FULL;
          buf_ir_n    = imem_rdata;
          buf_valid_n = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect) begin
          enter       = 1'b1;
          req_addr_n  = target;
          buf_valid_n = 1'b0;
        end else if (flow) begin
          enter       = 1'b1;
          req_addr_n  = pc_inc;
          buf_valid_n = 1'b0;
        end
      end
      S_DRAIN: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          enter      = 1'b1;
          req_addr_n = pc_n;
        end
      end
      S_FAULT: begin
        if (redirect) begin
          enter      = 1'b1;
          req_addr_n = target;
        end
      end
      default: state_n = S_BOOT;
    endcase

    if (enter) begin
`ifdef IF_ALIGN_CHECK_EN
      state_n = (req_addr_n[1:0] != 2'b00) ? S_FAULT : S_REQ;
`else
      state_n = S_REQ;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_BOOT;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      buf_ir    <= `IR_NON;
      buf_valid <= 1'b0;
      if_IR     <= `IR_NON;
      if_NPC    <= RESET_PC;
      adel      <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_addr  <= req_addr_n;
      buf_ir    <= buf_ir_n;
      buf_valid <= buf_valid_n;
      if_IR     <= ir_n;
      if_NPC    <= npc_n;
      adel      <= adel_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch with a variable-latency imem model.
`default_nettype none

`ifndef COND_FLOW
`define COND_FLOW  2'b00
`endif
`ifndef COND_STALL
`define COND_STALL 2'b01
`endif
`ifndef COND_ZERO
`define COND_ZERO  2'b10
`endif
`ifndef IR_NON
`define IR_NON     32'h0000_0000
`endif

module tb_instruction_fetch;

  localparam logic [31:0] RP = 32'h0040_0000;

  logic        clk, rst;
  logic [1:0]  cond;
  logic [2:0]  sel;
  logic [31:0] ext_out, connect, regfile_Rs, cp0_EPC, cp0_intr_addr;
  logic        imem_req, imem_ready, fetch_busy, if_adel;
  logic [31:0] imem_addr, imem_rdata, if_IR, if_NPC;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat = 0;
  int   wcnt;

  instruction_fetch #(.RESET_PC(RP)) dut (
    .clk(clk), .rst(rst), .cond(cond), .mux_pc_sel(sel), .ext_out(ext_out),
    .connect(connect), .regfile_Rs(regfile_Rs), .cp0_EPC(cp0_EPC),
    .cp0_intr_addr(cp0_intr_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_IR(if_IR),
    .if_NPC(if_NPC), .fetch_busy(fetch_busy), .if_adel(if_adel)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // imem: answers once a request has been waiting lat cycles (lat 0 = same cycle)
  assign imem_ready = imem_req && (wcnt >= lat);
  assign imem_rdata = memword(imem_addr);
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (imem_req && !imem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int l);
    lat = l; cond = `COND_FLOW; sel = 3'd0; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset(0);
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    checks++; if (if_IR !== `IR_NON) begin errors++; $display("FAIL rst_ir: got %h expected %h", if_IR, `IR_NON); end
    checks++; if (if_NPC !== RP) begin errors++; $display("FAIL rst_npc: got %h expected %h", if_NPC, RP); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (if_adel !== 1'b0) begin errors++; $display("FAIL rst_adel: got %b expected 0", if_adel); end
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", fetch_busy); end
  endtask

  task automatic test_zero_wait();
    exp_t e;
    int n = 0;
    int k = 0;
    apply_reset(0);
    for (int i = 0; i < 4; i++) exp_q.push_back('{ir: memword(RP + 4*i), npc: RP + 4*(i+1)});
    while (exp_q.size() != 0 && k < 12) begin
      if (imem_req === 1'b1) begin
        checks++; if (imem_addr !== RP + 4*n) begin errors++; $display("FAIL zw_addr%0d: got %h expected %h", n, imem_addr, RP + 4*n); end
      end
      cyc(); k++;
      if (if_IR !== `IR_NON) begin
        e = exp_q.pop_front(); n++;
        checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL zw_out%0d: got IR=%h NPC=%h expected IR=%h NPC=%h", n, if_IR, if_NPC, e.ir, e.npc); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zw_timeout: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
    checks++; if (k != 5) begin errors++; $display("FAIL zw_cycles: got %0d expected 5", k); end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    apply_reset(3);
    exp_q.push_back('{ir: memword(RP), npc: RP + 4});
    exp_q.push_back('{ir: memword(RP + 4), npc: RP + 8});
    cyc();
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== RP) begin errors++; $display("FAIL mw_addr%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, RP); end
      checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL mw_busy%0d: got %b expected 1", i, fetch_busy); end
      cyc();
      checks++; if (if_IR !== `IR_NON) begin errors++; $display("FAIL mw_bubble%0d: got %h expected %h", i, if_IR, `IR_NON); end
    end
    checks++; if (fetch_busy !== 1'b0 || imem_ready !== 1'b1) begin errors++; $display("FAIL mw_ready: got busy=%b ready=%b expected busy=0 ready=1", fetch_busy, imem_ready); end
    cyc();
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL mw_out0: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
    lat = 0;
    cyc();
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL mw_out1: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
  endtask

  task automatic test_branch();
    exp_t e;
    apply_reset(0);
    for (int i = 0; i < 4; i++) exp_q.push_back('{ir: memword(RP + 4*i), npc: RP + 4*(i+1)});
    exp_q.push_back('{ir: memword(32'h0040_001C), npc: 32'h0040_0020});
    exp_q.push_back('{ir: memword(32'h0040_0010), npc: 32'h0040_0014});
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL br_seq%0d: got IR=%h NPC=%h expected IR=%h NPC=%h", i, if_IR, if_NPC, e.ir, e.npc); end
    end
    sel = 3'd1; ext_out = 32'h0000_0003;
    #1;
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL br_busy: got %b expected 0", fetch_busy); end
    cyc();
    checks++; if (if_IR !== `IR_NON || if_NPC !== 32'h0040_0010 || imem_addr !== 32'h0040_001C) begin errors++; $display("FAIL br_redir: got IR=%h NPC=%h addr=%h expected IR=%h NPC=00400010 addr=0040001c", if_IR, if_NPC, imem_addr, `IR_NON); end
    sel = 3'd0;
    cyc();
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL br_target: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
    sel = 3'd1; ext_out = 32'hFFFF_FFFC;
    cyc();
    checks++; if (if_IR !== `IR_NON || imem_addr !== 32'h0040_0010) begin errors++; $display("FAIL br_back: got IR=%h addr=%h expected IR=%h addr=00400010", if_IR, imem_addr, `IR_NON); end
    sel = 3'd0;
    cyc();
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL br_back_out: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
  endtask

  task automatic test_stall();
    exp_t e;
    apply_reset(0);
    exp_q.push_back('{ir: memword(RP), npc: RP + 4});
    exp_q.push_back('{ir: memword(RP + 4), npc: RP + 8});
    exp_q.push_back('{ir: memword(RP + 8), npc: RP + 12});
    cyc(); cyc();
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL st_first: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
    cond = `COND_STALL;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (imem_req !== 1'b0 || if_IR !== memword(RP) || if_NPC !== RP + 4) begin errors++; $display("FAIL st_hold%0d: got req=%b IR=%h NPC=%h expected req=0 IR=%h NPC=%h", i, imem_req, if_IR, if_NPC, memword(RP), RP + 4); end
    end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL st_busy: got %b expected 0", fetch_busy); end
    cond = `COND_ZERO;
    cyc();
    checks++; if (if_IR !== `IR_NON || if_NPC !== RP + 4 || imem_req !== 1'b0) begin errors++; $display("FAIL st_zero: got IR=%h NPC=%h req=%b expected IR=%h NPC=%h req=0", if_IR, if_NPC, imem_req, `IR_NON, RP + 4); end
    cond = `COND_FLOW;
    cyc();
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL st_buf: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== RP + 8) begin errors++; $display("FAIL st_next: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RP + 8); end
    cyc();
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL st_after: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
  endtask

  task automatic test_intr_drain();
    exp_t e;
    apply_reset(2);
    exp_q.push_back('{ir: memword(32'h0040_0004), npc: 32'h0040_0008});
    cyc();
    sel = 3'd4; cp0_intr_addr = 32'h0040_0004;
    #1;
    checks++; if (fetch_busy !== 1'b0 || imem_ready !== 1'b0) begin errors++; $display("FAIL in_pre: got busy=%b ready=%b expected busy=0 ready=0", fetch_busy, imem_ready); end
    cyc();
    checks++; if (if_IR !== `IR_NON || if_NPC !== RP || imem_req !== 1'b1 || imem_addr !== RP) begin errors++; $display("FAIL in_drain: got IR=%h NPC=%h req=%b addr=%h expected IR=%h NPC=%h req=1 addr=%h", if_IR, if_NPC, imem_req, imem_addr, `IR_NON, RP, RP); end
    sel = 3'd0;
    #1;
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL in_busy: got %b expected 1", fetch_busy); end
    cyc();
    checks++; if (imem_addr !== RP || imem_ready !== 1'b1 || if_IR !== `IR_NON) begin errors++; $display("FAIL in_wait: got addr=%h ready=%b IR=%h expected addr=%h ready=1 IR=%h", imem_addr, imem_ready, if_IR, RP, `IR_NON); end
    cyc();
    checks++; if (if_IR !== `IR_NON || imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL in_drop: got IR=%h addr=%h expected IR=%h addr=00400004", if_IR, imem_addr, `IR_NON); end
    lat = 0;
    cyc();
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL in_out: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    apply_reset(2);
    exp_q.push_back('{ir: memword(32'h0040_0040), npc: 32'h0040_0044});
    exp_q.push_back('{ir: memword(32'h0040_0200), npc: 32'h0040_0204});
    cyc();
    sel = 3'd2; connect = 32'h0040_0080;
    cyc();
    sel = 3'd5; cp0_EPC = 32'h0040_0040;
    cyc();
    checks++; if (imem_addr !== RP || imem_req !== 1'b1) begin errors++; $display("FAIL bb_hold: got addr=%h req=%b expected addr=%h req=1", imem_addr, imem_req, RP); end
    sel = 3'd0;
    cyc();
    checks++; if (imem_addr !== 32'h0040_0040 || if_IR !== `IR_NON) begin errors++; $display("FAIL bb_epc: got addr=%h IR=%h expected addr=00400040 IR=%h", imem_addr, if_IR, `IR_NON); end
    lat = 0;
    cyc();
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL bb_out0: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
    sel = 3'd3; regfile_Rs = 32'h0040_0200;
    cyc();
    checks++; if (if_IR !== `IR_NON || if_NPC !== 32'h0040_0044 || imem_addr !== 32'h0040_0200) begin errors++; $display("FAIL bb_jr: got IR=%h NPC=%h addr=%h expected IR=%h NPC=00400044 addr=00400200", if_IR, if_NPC, imem_addr, `IR_NON); end
    sel = 3'd0;
    cyc();
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL bb_out1: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
  endtask

  task automatic test_misalign();
    exp_t e;
    apply_reset(0);
    cyc();
    sel = 3'd3; regfile_Rs = 32'h0040_0002;
    cyc();
    sel = 3'd0;
`ifdef IF_ALIGN_CHECK_EN
    exp_q.push_back('{ir: memword(32'h0040_0100), npc: 32'h0040_0104});
    checks++; if (imem_req !== 1'b0 || if_IR !== `IR_NON) begin errors++; $display("FAIL ma_noreq: got req=%b IR=%h expected req=0 IR=%h", imem_req, if_IR, `IR_NON); end
    cyc();
    checks++; if (if_adel !== 1'b1 || if_IR !== `IR_NON || if_NPC !== 32'h0040_0006) begin errors++; $display("FAIL ma_adel: got adel=%b IR=%h NPC=%h expected adel=1 IR=%h NPC=00400006", if_adel, if_IR, if_NPC, `IR_NON); end
    cyc();
    checks++; if (if_adel !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL ma_held: got adel=%b req=%b expected adel=1 req=0", if_adel, imem_req); end
    sel = 3'd5; cp0_EPC = 32'h0040_0100;
    cyc();
    checks++; if (if_adel !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL ma_eret: got adel=%b req=%b addr=%h expected adel=0 req=1 addr=00400100", if_adel, imem_req, imem_addr); end
    sel = 3'd0;
    cyc();
`else
    exp_q.push_back('{ir: memword(RP), npc: 32'h0040_0006});
    checks++; if (imem_req !== 1'b1 || imem_addr !== RP) begin errors++; $display("FAIL ma_addr: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RP); end
    cyc();
    checks++; if (if_adel !== 1'b0) begin errors++; $display("FAIL ma_adel: got %b expected 0", if_adel); end
`endif
    e = exp_q.pop_front();
    checks++; if (if_IR !== e.ir || if_NPC !== e.npc) begin errors++; $display("FAIL ma_out: got IR=%h NPC=%h expected IR=%h NPC=%h", if_IR, if_NPC, e.ir, e.npc); end
  endtask

  initial begin
    rst = 1'b1; cond = `COND_FLOW; sel = 3'd0; ext_out = '0; connect = '0;
    regfile_Rs = '0; cp0_EPC = '0; cp0_intr_addr = '0;
    test_reset();
    test_zero_wait();
    test_mem_wait();
    test_branch();
    test_stall();
    test_intr_drain();
    test_back_to_back();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
